// File: rtl/flow_storage_ram.sv
// ============================================================================
// flow_storage_ram : direct-mapped per-flow tag/valid/data table with
//                    hashed lookup, miss-claim and edit-handle writes.
// Revision 1.0
// ============================================================================
`default_nettype none

module flow_storage_ram #(
  parameter int FLOW_ID_WIDTH   = 32,
  parameter int FLOW_DATA_WIDTH = 64,
  parameter int EDIT_ID_WIDTH   = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       write_ready,
  input  logic                       write_en,
  input  logic [EDIT_ID_WIDTH-1:0]   write_edit_id,
  input  logic [FLOW_DATA_WIDTH-1:0] write_data,
  output logic                       read_ready,
  input  logic                       read_en,
  input  logic [FLOW_ID_WIDTH-1:0]   read_id,
  output logic [EDIT_ID_WIDTH-1:0]   read_edit_id,
  output logic [FLOW_DATA_WIDTH-1:0] read_data,
  output logic                       read_data_new,
  output logic                       read_data_found
);

  localparam int DEPTH  = 1 << EDIT_ID_WIDTH;
  localparam int NCHUNK = (FLOW_ID_WIDTH + EDIT_ID_WIDTH - 1) / EDIT_ID_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [EDIT_ID_WIDTH-1:0] hash_f(input logic [FLOW_ID_WIDTH-1:0] id);
    logic [NCHUNK*EDIT_ID_WIDTH-1:0] padded;
    logic [EDIT_ID_WIDTH-1:0]        h;
    padded                   = '0;
    padded[FLOW_ID_WIDTH-1:0] = id;
    h                        = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      h = h ^ padded[k*EDIT_ID_WIDTH +: EDIT_ID_WIDTH];
    end
    return h;
  endfunction

  logic [0:0]               state_q, state_d;
  logic [EDIT_ID_WIDTH-1:0] cnt_q, cnt_d;

  logic                       tbl_valid_q [DEPTH];
  logic [FLOW_ID_WIDTH-1:0]   tbl_tag_q   [DEPTH];
  logic [FLOW_DATA_WIDTH-1:0] tbl_data_q  [DEPTH];

  logic                     s0_vld_q, s1_vld_q, s2_vld_q;
  logic [EDIT_ID_WIDTH-1:0] s0_idx_q, s1_idx_q, s2_idx_q;
  logic [FLOW_ID_WIDTH-1:0] s0_id_q,  s1_id_q,  s2_id_q;

  logic                       w_rd_acc, w_wr_acc, w_fwd, w_valid, w_hit, w_claim;
  logic [FLOW_DATA_WIDTH-1:0] w_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = ST_RUN;
    end
  end

  always_comb begin
    read_ready  = (state_q == ST_RUN);
    write_ready = (state_q == ST_RUN);
  end

  assign w_rd_acc = read_en  & read_ready;
  assign w_wr_acc = write_en & write_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_vld_q <= 1'b0;  s1_vld_q <= 1'b0;  s2_vld_q <= 1'b0;
      s0_idx_q <= '0;    s1_idx_q <= '0;    s2_idx_q <= '0;
      s0_id_q  <= '0;    s1_id_q  <= '0;    s2_id_q  <= '0;
    end else begin
      s0_vld_q <= w_rd_acc;
      s0_idx_q <= hash_f(read_id);
      s0_id_q  <= read_id;
      s1_vld_q <= s0_vld_q;
      s1_idx_q <= s0_idx_q;
      s1_id_q  <= s0_id_q;
      s2_vld_q <= s1_vld_q;
      s2_idx_q <= s1_idx_q;
      s2_id_q  <= s1_id_q;
    end
  end

  // The lookup happens in the result cycle, so earlier writes and claims are
  // already in the table; only a same-cycle write needs forwarding.
  assign w_fwd   = w_wr_acc && (write_edit_id == s2_idx_q);
  assign w_valid = w_fwd | tbl_valid_q[s2_idx_q];
  assign w_data  = w_fwd ? write_data : tbl_data_q[s2_idx_q];
  assign w_hit   = s2_vld_q && w_valid && (tbl_tag_q[s2_idx_q] == s2_id_q);
  assign w_claim = s2_vld_q && !w_hit;

  assign read_data_new   = s2_vld_q;
  assign read_data_found = w_hit;
  assign read_data       = w_hit ? w_data : '0;
  assign read_edit_id    = s2_idx_q;

  // Claim is applied after the write so a same-slot miss leaves valid cleared.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) tbl_valid_q[cnt_q] <= 1'b0;
    if (w_wr_acc) begin
      tbl_data_q[write_edit_id]  <= write_data;
      tbl_valid_q[write_edit_id] <= 1'b1;
    end
    if (w_claim) begin
      tbl_tag_q[s2_idx_q]   <= s2_id_q;
      tbl_valid_q[s2_idx_q] <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flow_storage_ram.sv
// Directed scoreboard bench for flow_storage_ram (default parameters).
`default_nettype none

module tb_flow_storage_ram;
  localparam int FIW   = 32;
  localparam int FDW   = 64;
  localparam int EW    = 10;
  localparam int DEPTH = 1024;

  logic           clk;
  logic           reset;
  logic           write_ready, write_en;
  logic [EW-1:0]  write_edit_id;
  logic [FDW-1:0] write_data;
  logic           read_ready, read_en;
  logic [FIW-1:0] read_id;
  logic [EW-1:0]  read_edit_id;
  logic [FDW-1:0] read_data;
  logic           read_data_new, read_data_found;

  flow_storage_ram dut (
    .clk(clk), .reset(reset),
    .write_ready(write_ready), .write_en(write_en),
    .write_edit_id(write_edit_id), .write_data(write_data),
    .read_ready(read_ready), .read_en(read_en), .read_id(read_id),
    .read_edit_id(read_edit_id), .read_data(read_data),
    .read_data_new(read_data_new), .read_data_found(read_data_found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [EW-1:0]  idx;
    logic           found;
    logic [FDW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  logic [FIW-1:0] m_tag   [DEPTH];
  bit             m_valid [DEPTH];
  logic [FDW-1:0] m_data  [DEPTH];

  function automatic logic [EW-1:0] hash(input logic [FIW-1:0] id);
    return id[9:0] ^ id[19:10] ^ id[29:20] ^ {8'b0, id[31:30]};
  endfunction

  task automatic chk(input string tag, input logic [FDW-1:0] got, input logic [FDW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  // Sequential model of one lookup; a miss claims the slot.
  task automatic read_push(input logic [FIW-1:0] id);
    exp_t e;
    logic [EW-1:0] ix;
    ix      = hash(id);
    e.idx   = ix;
    e.found = m_valid[ix] && (m_tag[ix] == id);
    e.data  = e.found ? m_data[ix] : '0;
    if (!e.found) begin
      m_tag[ix]   = id;
      m_valid[ix] = 1'b0;
    end
    sb.push_back(e);
    read_en = 1'b1;
    read_id = id;
    step();
    read_en = 1'b0;
  endtask

  task automatic wr(input logic [EW-1:0] ix, input logic [FDW-1:0] d);
    m_data[ix]    = d;
    m_valid[ix]   = 1'b1;
    write_en      = 1'b1;
    write_edit_id = ix;
    write_data    = d;
    step();
    write_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!read_ready && n < 2000) begin
      step();
      n++;
    end
    chk(tag, n, DEPTH);
    chk({tag, "_wr_ready"}, write_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read_ready"}, read_ready, 0);
    chk({tag, "_write_ready"}, write_ready, 0);
    chk({tag, "_new"}, read_data_new, 0);
    chk({tag, "_found"}, read_data_found, 0);
    chk({tag, "_data"}, read_data, 0);
    chk({tag, "_edit_id"}, read_edit_id, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (read_data_new) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rd_edit_id", read_edit_id, e.idx);
        chk("rd_found", read_data_found, e.found);
        chk("rd_data", read_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1'b0; read_en = 1'b0; write_en = 1'b0;
    read_id = '0; write_edit_id = '0; write_data = '0;
    clear_model();
    repeat (3) step();
    chk_reset_outputs("rst0");

    reset = 1'b1;
    wait_ready("init_cycles");

    // Fresh table: all misses, then store data = id through returned handles.
    for (int id = 1; id <= 11; id++) read_push(id);
    drain();
    for (int id = 1; id <= 11; id++) wr(hash(id), FDW'(id));
    for (int id = 1; id <= 11; id++) read_push(id);
    drain();

    // Write lands in the same cycle as the first result; both reads see 0xAB.
    e.idx = hash(5); e.found = 1'b1; e.data = 64'hAB;
    sb.push_back(e);
    read_en = 1'b1; read_id = 32'd5;
    step();
    read_en = 1'b0;
    step();
    step();
    m_data[hash(5)] = 64'hAB;
    m_valid[hash(5)] = 1'b1;
    write_en = 1'b1; write_edit_id = hash(5); write_data = 64'hAB;
    read_push(32'd5);
    write_en = 1'b0;
    drain();

    // Simultaneous read and write to different slots.
    m_data[hash(2)] = 64'h22;
    m_valid[hash(2)] = 1'b1;
    write_en = 1'b1; write_edit_id = hash(2); write_data = 64'h22;
    read_push(32'd3);
    write_en = 1'b0;
    read_push(32'd2);
    drain();

    // Colliding IDs: B evicts A, then A misses and reclaims.
    wr(hash(32'h1), 64'd7);
    read_push(32'h400);
    read_push(32'h1);
    drain();

    // Reset with two reads in flight: no results, table re-initialised.
    read_en = 1'b1; read_id = 32'd3;
    step();
    read_id = 32'd4;
    step();
    read_en = 1'b0;
    reset = 1'b0;
    repeat (4) step();
    chk_reset_outputs("rst1");
    reset = 1'b1;
    clear_model();
    wait_ready("reinit_cycles");
    read_push(32'd3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
